ni_flit_receiver: RTL and testbench
===================================

// Module: ni_flit_receiver
// PURPOSE
//  Receive-side network interface. Accepts 18-bit flits from the router's local
//  output port, checks the head flit's destination against this node, and writes
//  payload words to local SRAM at consecutive addresses. Pulses packet_end once
//  per delivered packet. Mirror of the SRAM-fed packetizer on the transmit side.
// PARAMETERS
//  NODE_W   4    destination-id field width in head flit
//  ADDR_W   12   SRAM word-address width (NODE_W+ADDR_W == 16)
//  MAX_LEN  8    max payload words per packet (body + tail flits)
// PORTS
//  clk            in   1       system clock, all logic on posedge
//  reset          in   1       asynchronous, active-high reset
//  flit_in        in   18      {type[1:0], payload[15:0]}
//  flit_valid     in   1       flit_in valid
//  flit_ready     out  1       receiver can accept; transfer on valid&ready at posedge
//  node_id        in   NODE_W  this node's id, static
//  sram_we        out  1       SRAM write strobe, one cycle per word
//  sram_addr      out  ADDR_W  SRAM write address
//  sram_data_out  out  16      SRAM write data
//  packet_end     out  1       1-cycle pulse: packet completed
//  pkt_drop       out  1       1-cycle pulse: packet discarded (wrong dest)
//  pkt_err        out  1       1-cycle pulse: protocol/length/checksum error
//  pkt_count      out  8       delivered-packet counter, wraps 255->0
// BEHAVIOUR
//  Flit types: 01 HEAD, 00 BODY, 10 TAIL, 11 HEAD+TAIL (single flit, zero data).
//  HEAD payload = {dest[NODE_W-1:0], base_addr[ADDR_W-1:0]}; BODY/TAIL = data.
//  Reset: state IDLE; all outputs 0 except flit_ready=0 while reset, 1 after.
//  FSM: IDLE, RECV, DROP, DONE.
//   IDLE: HEAD & dest==node_id -> load addr=base_addr, len=0, RECV.
//         HEAD & dest!=node_id -> DROP. HEAD+TAIL -> DONE (match) / pkt_drop (mismatch).
//         BODY/TAIL in IDLE -> discarded, pkt_err pulse, stay IDLE.
//   RECV: BODY/TAIL -> write word, addr+1 (wraps modulo 2^ADDR_W), len+1.
//         TAIL -> DONE. len reaching MAX_LEN without TAIL -> pkt_err, DROP.
//         HEAD in RECV -> pkt_err, abort current (no packet_end), process new head as IDLE.
//   DROP: consume flits, no writes, until TAIL -> IDLE with pkt_drop pulse
//         (pkt_err instead if entered via length overflow).
//   DONE: one cycle, flit_ready=0, packet_end=1, pkt_count+1, -> IDLE.
//  Latency: sram_we/addr/data registered, asserted the cycle after acceptance;
//   packet_end asserted the cycle after tail's SRAM write (2 cycles after tail accept).
//  flit_ready=1 in IDLE/RECV/DROP, 0 in DONE. No transfer when flit_valid=0.
//  Reset mid-packet: packet abandoned silently, no pulses, SRAM writes already made stand.
// CONFIGURATION
//  NI_CHECKSUM_EN defined: TAIL payload is XOR of all BODY words and is NOT written;
//   mismatch -> pkt_err instead of packet_end, pkt_count unchanged. MAX_LEN counts BODY only.
//  Undefined: TAIL carries data and is written like BODY; no checksum logic.
// STRUCTURE
//  Shared package ni_pkg: flit type localparams (FLIT_HEAD/BODY/TAIL/HT), FLIT_W=18,
//   flit field offsets; same package used by the transmit packetizer.
//  No sub-module required; optional ni_flit_decode (combinational type/field split)
//   shared with packetizer bench.
// TESTING
//  1 node_id=3; HEAD{3,0x010}, BODY AAAA, BODY BBBB, TAIL CCCC -> writes 0x010=AAAA,
//    0x011=BBBB, 0x012=CCCC; packet_end one pulse; pkt_count=1.
//  2 HEAD{5,0x020}, BODY 1111, TAIL 2222 -> no sram_we, pkt_drop pulse at tail,
//    pkt_count unchanged.
//  3 HEAD{3,0xFFF}, BODY 1, TAIL 2 -> writes 0xFFF then 0x000 (wrap).
//  4 HEAD{3,0}, 9 BODY flits (MAX_LEN=8) -> 8 writes, pkt_err, rest dropped until TAIL.
//  5 reset asserted after 2nd BODY -> outputs 0 immediately; next HEAD{3,0x040},TAIL 5 ok.
//  6 NI_CHECKSUM_EN: BODY 00FF, BODY FF00, TAIL FFFF -> packet_end; TAIL 0000 -> pkt_err.
//  All cases: random flit_valid gaps; verify DONE cycle deasserts flit_ready.

Source files
------------

// File: rtl/ni_pkg.sv
// Flit format shared by the NI receiver and the transmit packetizer.
package ni_pkg;

    localparam int FLIT_W    = 18;
    localparam int PAYLOAD_W = 16;
    localparam int TYPE_LSB  = 16;

    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;
    localparam logic [1:0] FLIT_HT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP,
        ST_DONE
    } rx_state_t;

endpackage

// File: rtl/ni_flit_receiver_if.sv
// Flit channel from the router's local output port into the NI receiver.
interface ni_flit_receiver_if;
    import ni_pkg::*;

    logic [FLIT_W-1:0] flit_in;
    logic              flit_valid;
    logic              flit_ready;

    modport master (output flit_in, output flit_valid, input flit_ready);
    modport slave  (input flit_in, input flit_valid, output flit_ready);

endinterface

// File: rtl/ni_flit_decode.sv
// Combinational split of a flit into type, head fields and data word.
module ni_flit_decode
    import ni_pkg::*;
#(
    parameter int NODE_W = 4,
    parameter int ADDR_W = 12
) (
    input  logic [FLIT_W-1:0]    flit,
    output logic [1:0]           ftype,
    output logic [NODE_W-1:0]    dest,
    output logic [ADDR_W-1:0]    base_addr,
    output logic [PAYLOAD_W-1:0] data
);

    assign ftype     = flit[TYPE_LSB +: 2];
    assign data      = flit[PAYLOAD_W-1:0];
    assign dest      = data[PAYLOAD_W-1 -: NODE_W];
    assign base_addr = data[ADDR_W-1:0];

endmodule

// File: rtl/ni_flit_receiver.sv
// Receive-side network interface: filters packets by destination and writes payload to SRAM.
// Build option NI_CHECKSUM_EN: TAIL carries the XOR of the BODY words instead of data.
module ni_flit_receiver
    import ni_pkg::*;
#(
    parameter int NODE_W  = 4,
    parameter int ADDR_W  = 12,
    parameter int MAX_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    ni_flit_receiver_if.slave    flit_bus,
    input  logic [NODE_W-1:0]    node_id,
    output logic                 sram_we,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [PAYLOAD_W-1:0] sram_data_out,
    output logic                 packet_end,
    output logic                 pkt_drop,
    output logic                 pkt_err,
    output logic [7:0]           pkt_count
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    rx_state_t            state;
    logic                 flit_ready_r;
    logic                 ovf;
    logic [ADDR_W-1:0]    addr;
    logic [LEN_W-1:0]     len;
`ifdef NI_CHECKSUM_EN
    logic [PAYLOAD_W-1:0] csum;
`endif

    logic [1:0]           ftype;
    logic [NODE_W-1:0]    dest;
    logic [ADDR_W-1:0]    base_addr;
    logic [PAYLOAD_W-1:0] data;
    logic                 accept;
    logic                 is_head;
    logic                 dest_hit;

    ni_flit_decode #(
        .NODE_W (NODE_W),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .flit      (flit_bus.flit_in),
        .ftype     (ftype),
        .dest      (dest),
        .base_addr (base_addr),
        .data      (data)
    );

    assign flit_bus.flit_ready = flit_ready_r;
    assign accept   = flit_bus.flit_valid & flit_ready_r;
    assign is_head  = (ftype == FLIT_HEAD) || (ftype == FLIT_HT);
    assign dest_hit = (dest == node_id);

    // ovf marks a DROP entered by length overflow, so its TAIL reports pkt_err rather than pkt_drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            flit_ready_r  <= 1'b0;
            ovf           <= 1'b0;
            addr          <= '0;
            len           <= '0;
`ifdef NI_CHECKSUM_EN
            csum          <= '0;
`endif
            sram_we       <= 1'b0;
            sram_addr     <= '0;
            sram_data_out <= '0;
            packet_end    <= 1'b0;
            pkt_drop      <= 1'b0;
            pkt_err       <= 1'b0;
            pkt_count     <= 8'd0;
        end else begin
            sram_we      <= 1'b0;
            packet_end   <= 1'b0;
            pkt_drop     <= 1'b0;
            pkt_err      <= 1'b0;
            flit_ready_r <= 1'b1;

            if (state == ST_DONE) begin
                packet_end <= 1'b1;
                pkt_count  <= pkt_count + 8'd1;
                state      <= ST_IDLE;
            end else if (accept) begin
                // A head arriving mid-packet aborts the old packet and starts over as if idle.
                if (is_head && state != ST_DROP) begin
                    if (state == ST_RECV) pkt_err <= 1'b1;
                    if (!dest_hit) begin
                        if (ftype == FLIT_HT) begin
                            pkt_drop <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            ovf   <= 1'b0;
                            state <= ST_DROP;
                        end
                    end else if (ftype == FLIT_HT) begin
                        flit_ready_r <= 1'b0;
                        state        <= ST_DONE;
                    end else begin
                        addr  <= base_addr;
                        len   <= '0;
`ifdef NI_CHECKSUM_EN
                        csum  <= '0;
`endif
                        state <= ST_RECV;
                    end
                end else begin
                    case (state)
                        ST_IDLE: pkt_err <= 1'b1;
                        ST_RECV: begin
`ifdef NI_CHECKSUM_EN
                            if (ftype == FLIT_TAIL) begin
                                if (csum == data) begin
                                    flit_ready_r <= 1'b0;
                                    state        <= ST_DONE;
                                end else begin
                                    pkt_err <= 1'b1;
                                    state   <= ST_IDLE;
                                end
                            end else if (len == LEN_W'(MAX_LEN)) begin
                                ovf   <= 1'b1;
                                state <= ST_DROP;
                            end else begin
                                sram_we       <= 1'b1;
                                sram_addr     <= addr;
                                sram_data_out <= data;
                                addr          <= addr + 1'b1;
                                len           <= len + 1'b1;
                                csum          <= csum ^ data;
                            end
`else
                            sram_we       <= 1'b1;
                            sram_addr     <= addr;
                            sram_data_out <= data;
                            addr          <= addr + 1'b1;
                            len           <= len + 1'b1;
                            if (ftype == FLIT_TAIL) begin
                                flit_ready_r <= 1'b0;
                                state        <= ST_DONE;
                            end else if (len == LEN_W'(MAX_LEN - 1)) begin
                                // Buffer full with no TAIL yet: the TAIL would be word MAX_LEN+1.
                                ovf   <= 1'b1;
                                state <= ST_DROP;
                            end
`endif
                        end
                        ST_DROP: begin
                            if (ftype == FLIT_TAIL) begin
                                if (ovf) pkt_err  <= 1'b1;
                                else     pkt_drop <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ni_flit_receiver.sv
// Directed bench for ni_flit_receiver with an SRAM-write scoreboard and pulse counters.
module tb_ni_flit_receiver;
    import ni_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  node_id;
    logic        sram_we;
    logic [11:0] sram_addr;
    logic [15:0] sram_data_out;
    logic        packet_end;
    logic        pkt_drop;
    logic        pkt_err;
    logic [7:0]  pkt_count;

    ni_flit_receiver_if bus ();

    ni_flit_receiver #(
        .NODE_W  (4),
        .ADDR_W  (12),
        .MAX_LEN (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flit_bus      (bus),
        .node_id       (node_id),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_data_out (sram_data_out),
        .packet_end    (packet_end),
        .pkt_drop      (pkt_drop),
        .pkt_err       (pkt_err),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int end_cnt = 0, drop_cnt = 0, err_cnt = 0;
    int exp_end = 0, exp_drop = 0, exp_err = 0, exp_count = 0;
    logic [27:0] wq[$];
    logic [15:0] words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every SRAM write is popped against the scoreboard; pulses are tallied.
    always @(negedge clk) begin
        logic [27:0] exp_w;
        if (reset === 1'b0) begin
            if (sram_we) begin
                if (wq.size() > 0) exp_w = wq.pop_front();
                else               exp_w = 'x;
                check("sram_write", {4'h0, sram_addr, sram_data_out}, {4'h0, exp_w});
            end
            if (packet_end) end_cnt++;
            if (pkt_drop)   drop_cnt++;
            if (pkt_err)    err_cnt++;
        end
    end

    function automatic logic [17:0] mk(input logic [1:0] t, input logic [15:0] p);
        return {t, p};
    endfunction

    task automatic send(input logic [17:0] f);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.flit_in    = f;
        bus.flit_valid = 1'b1;
        n = 0;
        while (bus.flit_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", {31'd0, bus.flit_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.flit_valid = 1'b0;
    endtask

    // Sends a packet built from 'words'; writes are identical in both build modes.
    task automatic pkt(input logic [3:0] dest, input logic [11:0] base);
        logic [11:0] a;
        logic [15:0] x;
        logic        hit;
        a   = base;
        x   = '0;
        hit = (dest == node_id);
        send(mk(FLIT_HEAD, {dest, base}));
        for (int i = 0; i < words.size(); i++) begin
            if (hit) wq.push_back({a, words[i]});
            a = a + 12'd1;
`ifdef NI_CHECKSUM_EN
            x = x ^ words[i];
            send(mk(FLIT_BODY, words[i]));
`else
            send(mk((i == words.size() - 1) ? FLIT_TAIL : FLIT_BODY, words[i]));
`endif
        end
`ifdef NI_CHECKSUM_EN
        send(mk(FLIT_TAIL, x));
`endif
        if (hit) begin
            check("done_ready_low", {31'd0, bus.flit_ready}, 32'd0);
            @(negedge clk);
            check("packet_end_pulse", {31'd0, packet_end}, 32'd1);
            exp_end++;
            exp_count++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic settle(input string tag);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_end"},   end_cnt,   exp_end);
        check({tag, "_drop"},  drop_cnt,  exp_drop);
        check({tag, "_err"},   err_cnt,   exp_err);
        check({tag, "_count"}, {24'd0, pkt_count}, exp_count);
        check({tag, "_wq"},    wq.size(), 0);
    endtask

    initial begin
        reset          = 1'b1;
        node_id        = 4'd3;
        bus.flit_in    = '0;
        bus.flit_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, bus.flit_ready}, 32'd0);
        check("rst_outs", {sram_we, packet_end, pkt_drop, pkt_err, sram_addr, sram_data_out},
              32'd0);
        check("rst_count", {24'd0, pkt_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, bus.flit_ready}, 32'd1);

        // Basic delivery
        words = {16'hAAAA, 16'hBBBB, 16'hCCCC};
        pkt(4'd3, 12'h010);
        settle("t1");

        // Wrong destination
        words = {16'h1111, 16'h2222};
        pkt(4'd5, 12'h020);
        settle("t2");

        // Address wrap
        words = {16'h0001, 16'h0002};
        pkt(4'd3, 12'hFFF);
        settle("t3");

        // Length overflow: nine BODY flits
        send(mk(FLIT_HEAD, {4'd3, 12'h000}));
        for (int i = 0; i < 9; i++) begin
            if (i < 8) wq.push_back({12'(i), 16'h1000 + 16'(i)});
            send(mk(FLIT_BODY, 16'h1000 + 16'(i)));
        end
        send(mk(FLIT_TAIL, 16'h0EEE));
        exp_err++;
        settle("t4");

        // Stray BODY in idle, single-flit packets
        send(mk(FLIT_BODY, 16'h1234));
        exp_err++;
        send(mk(FLIT_HT, {4'd7, 12'h000}));
        exp_drop++;
        send(mk(FLIT_HT, {4'd3, 12'h000}));
        check("ht_done_ready_low", {31'd0, bus.flit_ready}, 32'd0);
        @(negedge clk);
        check("ht_packet_end", {31'd0, packet_end}, 32'd1);
        exp_end++;
        exp_count++;
        settle("t_misc");

        // Head while receiving aborts the current packet
        send(mk(FLIT_HEAD, {4'd3, 12'h100}));
        wq.push_back({12'h100, 16'h7777});
        send(mk(FLIT_BODY, 16'h7777));
        exp_err++;
        words = {16'h8888};
        pkt(4'd3, 12'h200);
        settle("t7");

        // Reset mid-packet
        send(mk(FLIT_HEAD, {4'd3, 12'h030}));
        wq.push_back({12'h030, 16'h5A01});
        send(mk(FLIT_BODY, 16'h5A01));
        wq.push_back({12'h031, 16'h5A02});
        send(mk(FLIT_BODY, 16'h5A02));
        #2 reset = 1'b1;
        #1;
        check("midrst_outs", {sram_we, packet_end, pkt_drop, pkt_err, sram_addr, sram_data_out},
              32'd0);
        check("midrst_ready", {31'd0, bus.flit_ready}, 32'd0);
        check("midrst_count", {24'd0, pkt_count}, 32'd0);
        exp_count = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        words = {16'h0005};
        pkt(4'd3, 12'h040);
        settle("t5");

`ifdef NI_CHECKSUM_EN
        // Checksum good, then bad
        words = {16'h00FF, 16'hFF00};
        pkt(4'd3, 12'h050);
        send(mk(FLIT_HEAD, {4'd3, 12'h060}));
        wq.push_back({12'h060, 16'h00FF});
        send(mk(FLIT_BODY, 16'h00FF));
        wq.push_back({12'h061, 16'hFF00});
        send(mk(FLIT_BODY, 16'hFF00));
        send(mk(FLIT_TAIL, 16'h0000));
        exp_err++;
        settle("t6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
